// File: rtl/mul_or_div.sv
// mul_or_div: sequential unsigned 32x32 multiplier / 64-by-32 divider.
//
// One shared datapath (hi/lo shift register pair plus a 33-bit adder or
// subtractor) runs 32 iterations per operation, one bit per clock. A start
// pulse in IDLE or DONE latches the operands. The 64-bit result appears
// 33 cycles later together with a level valid flag.
//
// Build option:
//   MUL_OR_DIV_DIVIDE_EN  defined     -> divide path present, muordi selects
//                                        0 = multiply, 1 = divide.
//                         not defined -> multiply only, muordi ignored.
//
// Datapath usage
//   multiply: hi = running upper partial product, lo = multiplier bits still
//             to be consumed, with product bits shifting in from the top.
//             After 32 steps {hi, lo} is the full 64-bit product.
//   divide:   hi = running remainder, lo = dividend bits still to be consumed,
//             with quotient bits shifting in from the bottom.
//             After 32 steps hi is the remainder and lo is the quotient.
//
// Divide overflow (divisor zero, or dividend[63:32] >= divisor) is detected
// when the operands are latched. The operation still runs the full 32
// iterations so the timing does not depend on the data, and the final
// result is forced to all ones.

`timescale 1ns/1ps

module mul_or_div (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] opera1,
    input  logic [63:0] opera2,
    input  logic        muordi,
    input  logic        start,
    output logic [63:0] result,
    output logic        valid
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0]  LAST_ITER = 6'd32;
    localparam logic [63:0] ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    // One shift-add multiply iteration. The lsb of lo decides whether the
    // multiplicand is added into hi. The 33-bit sum and lo then shift right
    // by one bit together.
    function automatic logic [63:0] mul_step(input logic [31:0] hi,
                                             input logic [31:0] lo,
                                             input logic [31:0] a);
        logic [32:0] sum;
        if (lo[0]) begin
            sum = {1'b0, hi} + {1'b0, a};
        end else begin
            sum = {1'b0, hi};
        end
        return {sum[32:1], sum[0], lo[31:1]};
    endfunction

`ifdef MUL_OR_DIV_DIVIDE_EN
    // One restoring-divide iteration. The remainder and the dividend shift
    // left by one bit together, and the divisor is subtracted only when it
    // fits. The remainder stays below the divisor, so the shifted value fits
    // in 33 bits and the difference fits in 32 bits.
    function automatic logic [63:0] div_step(input logic [31:0] hi,
                                             input logic [31:0] lo,
                                             input logic [31:0] a);
        logic [32:0] rem;
        logic [31:0] diff;
        rem  = {hi, lo[31]};
        diff = rem[31:0] - a;
        if (rem >= {1'b0, a}) begin
            return {diff, lo[30:0], 1'b1};
        end else begin
            return {rem[31:0], lo[30:0], 1'b0};
        end
    endfunction
`endif

    logic [1:0]  state_q,  state_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic [31:0] opa_q,    opa_d;
    logic [31:0] hi_q,     hi_d;
    logic [31:0] lo_q,     lo_d;
    logic        div_q,    div_d;
    logic        ovf_q,    ovf_d;
    logic [63:0] result_q, result_d;
    logic        valid_q,  valid_d;

    logic [63:0] step_s;
    logic        div_sel_s;
    logic        ovf_start_s;

`ifdef MUL_OR_DIV_DIVIDE_EN
    assign div_sel_s   = muordi;
    assign ovf_start_s = muordi & (opera2[63:32] >= opera1);
    assign step_s      = div_q ? div_step(hi_q, lo_q, opa_q)
                               : mul_step(hi_q, lo_q, opa_q);
`else
    logic unused_s;
    assign div_sel_s   = 1'b0;
    assign ovf_start_s = 1'b0;
    assign step_s      = mul_step(hi_q, lo_q, opa_q);
    assign unused_s    = ^{muordi, opera2[63:32], div_q};
`endif

    // Next-state logic: accept operands, iterate, then finalise the result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_d    = div_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        valid_d  = valid_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    opa_d   = opera1;
                    hi_d    = div_sel_s ? opera2[63:32] : 32'd0;
                    lo_d    = opera2[31:0];
                    div_d   = div_sel_s;
                    ovf_d   = ovf_start_s;
                    cnt_d   = 6'd0;
                    valid_d = 1'b0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BUSY: begin
                if (cnt_q != LAST_ITER) begin
                    hi_d     = step_s[63:32];
                    lo_d     = step_s[31:0];
                    result_d = step_s;
                    cnt_d    = cnt_q + 6'd1;
                end else begin
                    result_d = ovf_q ? ALL_ONES : {hi_q, lo_q};
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset clearing everything.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            opa_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            div_q    <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= 64'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            div_q    <= div_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_mul_or_div.sv
// Directed self-checking bench for mul_or_div. Expected values are hand
// computed. Vectors with muordi = 1 expect quotient/remainder when
// MUL_OR_DIV_DIVIDE_EN is defined and a plain product otherwise.

`timescale 1ns/1ps

module tb_mul_or_div;

    logic        clock;
    logic        reset;
    logic [31:0] opera1;
    logic [63:0] opera2;
    logic        muordi;
    logic        start;
    logic [63:0] result;
    logic        valid;

    int checks;
    int errors;

`ifdef MUL_OR_DIV_DIVIDE_EN
    localparam logic [63:0] EXP_3_10     = 64'h0000_0001_0000_0003;
    localparam logic [63:0] EXP_0_9      = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_2_HI5    = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_7_100    = 64'h0000_0002_0000_000E;
    localparam logic [63:0] EXP_3_9_SEL1 = 64'h0000_0000_0000_0003;
`else
    localparam logic [63:0] EXP_3_10     = 64'h0000_0000_0000_001E;
    localparam logic [63:0] EXP_0_9      = 64'h0000_0000_0000_0000;
    localparam logic [63:0] EXP_2_HI5    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] EXP_7_100    = 64'h0000_0000_0000_02BC;
    localparam logic [63:0] EXP_3_9_SEL1 = 64'h0000_0000_0000_001B;
`endif

    mul_or_div dut (
        .clock  (clock),
        .reset  (reset),
        .opera1 (opera1),
        .opera2 (opera2),
        .muordi (muordi),
        .start  (start),
        .result (result),
        .valid  (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, then scramble the operand inputs.
    // Returns at the falling edge just after the accepting edge.
    task automatic start_op(input logic [31:0] a, input logic [63:0] b, input logic m);
        @(negedge clock);
        opera1 = a;
        opera2 = b;
        muordi = m;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        opera1 = $urandom;
        opera2 = {$urandom, $urandom};
        muordi = 1'($urandom_range(1, 0));
        check("valid_clear_on_accept", {63'd0, valid}, 64'd0);
    endtask

    // Called at the falling edge after accepting edge N+32.
    task automatic check_final(input string tag, input logic [63:0] exp);
        check({tag, "_not_early"}, {63'd0, valid}, 64'd0);
        @(negedge clock);
        check({tag, "_valid"}, {63'd0, valid}, 64'd1);
        check({tag, "_result"}, result, exp);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        opera1 = 32'd0;
        opera2 = 64'd0;
        muordi = 1'b0;

        #12;
        check("reset_valid", {63'd0, valid}, 64'd0);
        check("reset_result", result, 64'd0);
        #7 reset = 1'b1;

        // Basic multiply.
        start_op(32'd3, 64'd9, 1'b0);
        repeat (32) @(negedge clock);
        check_final("mul_3x9", 64'h0000_0000_0000_001B);

        // The result stays stable in DONE.
        repeat (3) @(negedge clock);
        check("done_hold_valid", {63'd0, valid}, 64'd1);
        check("done_hold_result", result, 64'h0000_0000_0000_001B);

        // Largest multiply.
        start_op(32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0);
        repeat (32) @(negedge clock);
        check_final("mul_max", 64'hFFFF_FFFE_0000_0001);

        // Multiply ignores opera2[63:32].
        start_op(32'h0000_0010, 64'hDEAD_BEEF_0000_0100, 1'b0);
        repeat (32) @(negedge clock);
        check_final("mul_hi_ignored", 64'h0000_0000_0000_1000);

        // muordi = 1 vectors (divide, or multiply in a multiply-only build).
        start_op(32'd3, 64'd10, 1'b1);
        repeat (32) @(negedge clock);
        check_final("sel1_3_10", EXP_3_10);

        start_op(32'd0, 64'd9, 1'b1);
        repeat (32) @(negedge clock);
        check_final("sel1_0_9", EXP_0_9);

        start_op(32'd2, 64'h0000_0005_0000_0000, 1'b1);
        repeat (32) @(negedge clock);
        check_final("sel1_2_hi5", EXP_2_HI5);

        start_op(32'd7, 64'd100, 1'b1);
        repeat (32) @(negedge clock);
        check_final("sel1_7_100", EXP_7_100);

        start_op(32'd3, 64'd9, 1'b1);
        repeat (32) @(negedge clock);
        check_final("sel1_3_9", EXP_3_9_SEL1);

        // A start during BUSY is ignored.
        start_op(32'd5, 64'd6, 1'b0);
        repeat (9) @(negedge clock);
        opera1 = 32'd7;
        opera2 = 64'd8;
        muordi = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        repeat (22) @(negedge clock);
        check_final("busy_start_ignored", 64'h0000_0000_0000_001E);

        // Back-to-back: start held high, valid is high for exactly one cycle.
        @(negedge clock);
        opera1 = 32'd2;
        opera2 = 64'd3;
        muordi = 1'b0;
        start  = 1'b1;
        @(negedge clock);
        repeat (32) @(negedge clock);
        check_final("b2b_first", 64'h0000_0000_0000_0006);
        opera1 = 32'd4;
        opera2 = 64'd5;
        @(negedge clock);
        check("b2b_valid_one_cycle", {63'd0, valid}, 64'd0);
        start = 1'b0;
        repeat (32) @(negedge clock);
        check_final("b2b_second", 64'h0000_0000_0000_0014);

        // Reset during BUSY clears the outputs at once.
        start_op(32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 1'b0);
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_valid", {63'd0, valid}, 64'd0);
        check("abort_result", result, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        start_op(32'd12, 64'd12, 1'b0);
        repeat (32) @(negedge clock);
        check_final("after_abort", 64'h0000_0000_0000_0090);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_or_div.md
# mul_or_div

Sequential unsigned 32x32 multiplier / 64-by-32 divider sharing one datapath. Operands are captured on a start pulse, the operation runs for 32 iterations (one bit per clock), and the 64-bit result is presented with a level `valid` flag. It sits beside the integer ALU as its multi-cycle arithmetic unit.

## Interface
- No parameters; widths fixed: operand A 32 bits, operand B 64 bits, result 64 bits.
- `clock`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `opera1`  input  32  multiplicand (multiply) / divisor (divide).
- `opera2`  input  64  multiplier in bits [31:0], bits [63:32] ignored (multiply) / dividend (divide).
- `muordi`  input  1  operation select sampled with `start`: 0 = multiply, 1 = divide.
- `start`  input  1  launch request, sampled on rising edge.
- `result`  output  64  product, or {remainder[31:0], quotient[31:0]}.
- `valid`  output  1  high while `result` holds a completed result.

## Operation
- States: IDLE, BUSY, DONE.
- Reset (`reset` low, asynchronous): state IDLE, `result` = 0, `valid` = 0, iteration counter = 0, internal registers cleared.
- IDLE or DONE with `start` = 1: latch `opera1`, `opera2`, `muordi`; clear `valid`; counter = 0; go to BUSY.
- BUSY: one iteration per clock; `start` ignored; after the 32nd iteration go to DONE.
- DONE: `valid` = 1, `result` held stable until the next accepted `start` or reset.
- Multiply (unsigned shift-add): result = opera1 * opera2[31:0], full 64 bits, no overflow possible.
- Divide (unsigned restoring): dividend = opera2, divisor = opera1.
  - Normal: result[31:0] = quotient, result[63:32] = remainder.
  - Divisor = 0, or opera2[63:32] >= opera1 (quotient overflows 32 bits): result = 64'hFFFF_FFFF_FFFF_FFFF; still takes the full 32 iterations.
- Operand inputs may change freely after the accepting edge; only latched copies are used.

## Timing
- `start` accepted at rising edge N (state IDLE or DONE).
- Edges N+1 .. N+32: the 32 iterations.
- `valid` rises and `result` becomes final after edge N+33, i.e. 33 cycles of latency.
- `valid` falls after the accepting edge of a new `start`.
- `start` held high continuously: accepted again in DONE, so `valid` is high for exactly one cycle between back-to-back operations.
- `start` and reset asserted in the same cycle: reset wins.
- Reset during BUSY aborts immediately: `valid` = 0, `result` = 0.
- `result` is undefined-but-stable during BUSY and must not be relied on; implementations drive the running partial value.

## Configuration
- `MUL_OR_DIV_DIVIDE_EN` defined: divide path present; `muordi` selects the operation as above.
- Not defined: divide logic omitted; `muordi` ignored and every operation is a multiply with identical timing.

## Test plan
- Reset low 19 ns, then `start` = 1 for one cycle with opera1 = 3, opera2 = 9, muordi = 0 -> after 33 cycles `valid` = 1, result = 64'h0000_0000_0000_001B.
- opera1 = 32'hFFFF_FFFF, opera2 = 64'h0000_0000_FFFF_FFFF, multiply -> result = 64'hFFFF_FFFE_0000_0001.
- Divide with opera1 = 3, opera2 = 10 -> result = 64'h0000_0001_0000_0003 (remainder 1, quotient 3).
- Divide with opera1 = 0, opera2 = 9, then with opera1 = 2, opera2 = 64'h0000_0005_0000_0000 -> both give result = 64'hFFFF_FFFF_FFFF_FFFF.
- `start` pulsed again at cycle 10 of BUSY with new operands -> ignored; the original result is delivered at cycle 33.
- Reset pulsed low during BUSY -> `valid` = 0 and `result` = 0 immediately (asynchronously); a new `start` afterwards completes normally.
- Build without `MUL_OR_DIV_DIVIDE_EN`, muordi = 1, opera1 = 3, opera2 = 9 -> result = 27 (multiply).
